ps2_movement_keys: RTL and testbench



---
 rtl/ps2_movement_keys.sv | 166 ++++++++++++++++
 tb/tb_ps2_movement_keys.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_movement_keys.sv
// PS/2 keyboard receiver plus arrow-key decoder producing four "key held" flags.
// Receiver frames 11-bit PS/2 words; decoder tracks E0/F0 prefixes to set/clear flags.
//
// state      | meaning
// RX_IDLE    | waiting for the start-bit falling edge
// RX_RECV    | shifting d0..d7, parity, stop; timeout armed
// D_IDLE     | no prefix pending
// D_EXT      | E0 seen, next byte is an extended make or F0
// D_BRK      | F0 seen, next (non-extended) byte is ignored
// D_EXT_BRK  | E0 F0 seen, next byte is an extended release
module ps2_movement_keys #(
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int CNT_W          = 13
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       turn_right,
    output logic       turn_left,
    output logic       move_forward,
    output logic       move_backward,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_error
);

    localparam logic       RX_IDLE   = 1'b0;
    localparam logic       RX_RECV   = 1'b1;
    localparam logic [1:0] D_IDLE    = 2'd0;
    localparam logic [1:0] D_EXT     = 2'd1;
    localparam logic [1:0] D_BRK     = 2'd2;
    localparam logic [1:0] D_EXT_BRK = 2'd3;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       clk_sync;
    logic [1:0]       dat_sync;
    logic             clk_prev;
    logic             fall;
    logic             rx_state;
    logic [3:0]       bitcnt;
    logic [9:0]       shreg;
    logic [CNT_W-1:0] tmo_cnt;
    logic             frame_ok;
    logic [1:0]       dec_state;
    logic [3:0]       held;
    logic [3:0]       key_hit;

    assign fall = clk_prev & ~clk_sync[1];

    // shreg[0] holds the start bit, [8:1] the data byte, [9] parity; stop is still on the line
    assign frame_ok = ~shreg[0] & dat_sync[1] & (^shreg[9:1]);

    always_ff @(posedge clock) begin
        if (reset) begin
            clk_sync <= 2'b00;
            dat_sync <= 2'b00;
            clk_prev <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_dat};
            clk_prev <= clk_sync[1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_state    <= RX_IDLE;
            bitcnt      <= 4'd0;
            shreg       <= 10'd0;
            tmo_cnt     <= '0;
            scan_code   <= 8'd0;
            scan_valid  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            scan_valid  <= 1'b0;
            frame_error <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (fall) begin
                        shreg    <= {dat_sync[1], shreg[9:1]};
                        bitcnt   <= 4'd1;
                        tmo_cnt  <= '0;
                        rx_state <= RX_RECV;
                    end
                end
                default: begin
                    if (fall) begin
                        tmo_cnt <= '0;
                        if (bitcnt == 4'd10) begin
                            rx_state <= RX_IDLE;
                            bitcnt   <= 4'd0;
                            if (frame_ok) begin
                                scan_code  <= shreg[8:1];
                                scan_valid <= 1'b1;
                            end else begin
                                frame_error <= 1'b1;
                            end
                        end else begin
                            shreg  <= {dat_sync[1], shreg[9:1]};
                            bitcnt <= bitcnt + 4'd1;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        rx_state    <= RX_IDLE;
                        bitcnt      <= 4'd0;
                        tmo_cnt     <= '0;
                        frame_error <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // bit order of held/key_hit: {right, left, forward, backward}
    always_comb begin
        key_hit = 4'b0000;
        case (scan_code)
            8'h74:   key_hit = 4'b1000;
            8'h6B:   key_hit = 4'b0100;
            8'h75:   key_hit = 4'b0010;
            8'h72:   key_hit = 4'b0001;
            default: key_hit = 4'b0000;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dec_state <= D_IDLE;
            held      <= 4'b0000;
        end else if (frame_error) begin
            dec_state <= D_IDLE;
        end else if (scan_valid) begin
            case (dec_state)
                D_IDLE: begin
                    if (scan_code == 8'hE0)
                        dec_state <= D_EXT;
                    else if (scan_code == 8'hF0)
                        dec_state <= D_BRK;
                    else if (scan_code == 8'h00 || scan_code == 8'hFF)
                        held <= 4'b0000;
                end
                D_EXT: begin
                    if (scan_code == 8'hF0) begin
                        dec_state <= D_EXT_BRK;
                    end else if (scan_code != 8'hE0) begin
                        held      <= held | key_hit;
                        dec_state <= D_IDLE;
                    end
                end
                D_EXT_BRK: begin
                    held      <= held & ~key_hit;
                    dec_state <= D_IDLE;
                end
                default: dec_state <= D_IDLE;
            endcase
        end
    end

    assign turn_right    = held[3];
    assign turn_left     = held[2];
    assign move_forward  = held[1];
    assign move_backward = held[0];

endmodule

// File: tb/tb_ps2_movement_keys.sv
// Bench for ps2_movement_keys: bit-banged PS/2 frames checked against a prefix-queue model.
module tb_ps2_movement_keys;

    localparam int TMO  = 5000;
    localparam int HALF = 20;

    logic       clock = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_dat;
    logic       turn_right, turn_left, move_forward, move_backward;
    logic [7:0] scan_code;
    logic       scan_valid, frame_error;

    int n_checks = 0;
    int n_fail   = 0;
    int sv_seen  = 0;
    int fe_seen  = 0;

    logic [3:0] exp_flags;
    logic [7:0] exp_code;
    int         exp_sv = 0;
    int         exp_fe = 0;
    logic [7:0] q[$];

    wire [3:0] flags = {turn_right, turn_left, move_forward, move_backward};

    always #5 clock = ~clock;

    ps2_movement_keys #(.TIMEOUT_CYCLES(TMO), .CNT_W(13)) dut (
        .clock        (clock),
        .reset        (reset),
        .ps2_clk      (ps2_clk),
        .ps2_dat      (ps2_dat),
        .turn_right   (turn_right),
        .turn_left    (turn_left),
        .move_forward (move_forward),
        .move_backward(move_backward),
        .scan_code    (scan_code),
        .scan_valid   (scan_valid),
        .frame_error  (frame_error)
    );

    always @(negedge clock) begin
        if (scan_valid)  sv_seen++;
        if (frame_error) fe_seen++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got hang expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model: bytes collected until a complete key code forms
    function automatic logic [3:0] key_bit(input logic [7:0] b);
        case (b)
            8'h74:   return 4'b1000;
            8'h6B:   return 4'b0100;
            8'h75:   return 4'b0010;
            8'h72:   return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic model_byte(input logic [7:0] b);
        exp_sv++;
        exp_code = b;
        q.push_back(b);
        if (q.size() == 1 && (b == 8'hE0 || b == 8'hF0)) return;
        if (q.size() == 2 && q[0] == 8'hE0 && b == 8'hE0) begin
            void'(q.pop_back());
            return;
        end
        if (q.size() == 2 && q[0] == 8'hE0 && b == 8'hF0) return;
        if (q[0] == 8'hE0 && q.size() == 3)
            exp_flags = exp_flags & ~key_bit(b);
        else if (q[0] == 8'hE0)
            exp_flags = exp_flags | key_bit(b);
        else if (q[0] == 8'hF0)
            exp_flags = exp_flags;
        else if (b == 8'h00 || b == 8'hFF)
            exp_flags = 4'b0000;
        q.delete();
    endtask

    task automatic model_error();
        exp_fe++;
        q.delete();
    endtask

    task automatic model_reset();
        exp_flags = 4'b0000;
        exp_code  = 8'h00;
        q.delete();
    endtask

    // ---------------- PS/2 device driver
    function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic bad);
        return {1'b1, (~^d) ^ bad, d, 1'b0};
    endfunction

    task automatic ps2_bit(input logic b);
        @(negedge clock);
        ps2_dat = b;
        repeat (HALF) @(negedge clock);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clock);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad);
        logic [10:0] bits;
        bits = frame_bits(d, bad);
        for (int i = 0; i < 11; i++) ps2_bit(bits[i]);
        repeat (10) @(negedge clock);
        if (bad) model_error();
        else     model_byte(d);
    endtask

    // ---------------- tests
    task automatic test_reset();
        reset   = 1'b1;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        repeat (5) @(negedge clock);
        reset = 1'b0;
        model_reset();
        @(negedge clock);
        n_checks++;
        if (flags !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b expected %b", flags, 4'b0000); end
        n_checks++;
        if (scan_code !== 8'h00) begin n_fail++; $display("FAIL reset_scan_code: got %h expected %h", scan_code, 8'h00); end
        n_checks++;
        if (scan_valid !== 1'b0) begin n_fail++; $display("FAIL reset_scan_valid: got %b expected 0", scan_valid); end
        n_checks++;
        if (frame_error !== 1'b0) begin n_fail++; $display("FAIL reset_frame_error: got %b expected 0", frame_error); end
    endtask

    task automatic test_forward_press();
        logic [10:0] bits;
        send_frame(8'hE0, 1'b0);
        bits = frame_bits(8'h75, 1'b0);
        for (int i = 0; i < 10; i++) ps2_bit(bits[i]);
        @(negedge clock);
        ps2_dat = bits[10];
        repeat (HALF) @(negedge clock);
        ps2_clk = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        n_checks++;
        if (scan_valid !== 1'b1 || scan_code !== 8'h75) begin
            n_fail++; $display("FAIL press_scan_valid_timing: got valid=%b code=%h expected valid=1 code=75", scan_valid, scan_code);
        end
        n_checks++;
        if (move_forward !== 1'b0) begin n_fail++; $display("FAIL press_flag_early: got %b expected 0", move_forward); end
        @(posedge clock);
        #1;
        n_checks++;
        if (move_forward !== 1'b1 || scan_valid !== 1'b0) begin
            n_fail++; $display("FAIL press_flag_latency: got fwd=%b valid=%b expected fwd=1 valid=0", move_forward, scan_valid);
        end
        repeat (HALF) @(negedge clock);
        ps2_clk = 1'b1;
        repeat (10) @(negedge clock);
        model_byte(8'h75);
        n_checks++;
        if (flags !== exp_flags) begin n_fail++; $display("FAIL press_flags: got %b expected %b", flags, exp_flags); end
        n_checks++;
        if (sv_seen !== exp_sv) begin n_fail++; $display("FAIL press_valid_count: got %0d expected %0d", sv_seen, exp_sv); end
    endtask

    task automatic test_forward_release();
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        n_checks++;
        if (flags !== exp_flags || move_forward !== 1'b0) begin
            n_fail++; $display("FAIL release_flags: got %b expected %b", flags, exp_flags);
        end
        n_checks++;
        if (scan_code !== 8'h75) begin n_fail++; $display("FAIL release_scan_code: got %h expected 75", scan_code); end
    endtask

    task automatic test_two_keys();
        send_frame(8'hE0, 1'b0);
        send_frame(8'h74, 1'b0);
        send_frame(8'hE0, 1'b0);
        send_frame(8'h6B, 1'b0);
        n_checks++;
        if (flags !== 4'b1100 || flags !== exp_flags) begin
            n_fail++; $display("FAIL two_keys_held: got %b expected %b", flags, exp_flags);
        end
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h74, 1'b0);
        n_checks++;
        if (flags !== 4'b0100 || flags !== exp_flags) begin
            n_fail++; $display("FAIL two_keys_release_right: got %b expected %b", flags, exp_flags);
        end
    endtask

    task automatic test_bad_parity();
        int         sv_before, fe_before;
        logic [7:0] code_before;
        sv_before   = sv_seen;
        fe_before   = fe_seen;
        code_before = scan_code;
        send_frame(8'h75, 1'b1);
        n_checks++;
        if (fe_seen !== fe_before + 1) begin n_fail++; $display("FAIL parity_error_count: got %0d expected %0d", fe_seen - fe_before, 1); end
        n_checks++;
        if (sv_seen !== sv_before) begin n_fail++; $display("FAIL parity_no_valid: got %0d expected 0", sv_seen - sv_before); end
        n_checks++;
        if (flags !== exp_flags || scan_code !== code_before) begin
            n_fail++; $display("FAIL parity_state_kept: got flags=%b code=%h expected flags=%b code=%h", flags, scan_code, exp_flags, code_before);
        end
        send_frame(8'hE0, 1'b0);
        send_frame(8'h72, 1'b0);
        n_checks++;
        if (move_backward !== 1'b1 || flags !== exp_flags) begin
            n_fail++; $display("FAIL parity_recover_backward: got %b expected %b", flags, exp_flags);
        end
    endtask

    task automatic test_timeout();
        logic [10:0] bits;
        logic        early;
        int          fe_before;
        logic [7:0]  b;
        fe_before = fe_seen;
        bits = frame_bits(8'h3C, 1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(bits[i]);
        @(negedge clock);
        ps2_dat = bits[4];
        repeat (HALF) @(negedge clock);
        ps2_clk = 1'b0;
        repeat (3) @(posedge clock);
        early = 1'b0;
        for (int i = 1; i <= TMO; i++) begin
            @(posedge clock);
            #1;
            if (i == HALF) ps2_clk = 1'b1;
            if (i < TMO && frame_error) early = 1'b1;
        end
        n_checks++;
        if (frame_error !== 1'b1) begin n_fail++; $display("FAIL timeout_pulse_at_count: got %b expected 1", frame_error); end
        n_checks++;
        if (early !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got %b expected 0", early); end
        model_error();
        repeat (5) @(negedge clock);
        n_checks++;
        if (fe_seen !== fe_before + 1) begin n_fail++; $display("FAIL timeout_error_count: got %0d expected 1", fe_seen - fe_before); end
        b = 8'($urandom_range(1, 8'hDF));
        send_frame(b, 1'b0);
        n_checks++;
        if (scan_code !== b || flags !== exp_flags) begin
            n_fail++; $display("FAIL timeout_recover: got code=%h flags=%b expected code=%h flags=%b", scan_code, flags, b, exp_flags);
        end
    endtask

    task automatic test_nonext_overrun();
        send_frame(8'hE0, 1'b0); send_frame(8'h75, 1'b0);
        send_frame(8'hE0, 1'b0); send_frame(8'h72, 1'b0);
        send_frame(8'hE0, 1'b0); send_frame(8'h6B, 1'b0);
        send_frame(8'hE0, 1'b0); send_frame(8'h74, 1'b0);
        n_checks++;
        if (flags !== 4'b1111) begin n_fail++; $display("FAIL all_flags_set: got %b expected 1111", flags); end
        send_frame(8'h75, 1'b0);
        n_checks++;
        if (flags !== exp_flags || flags !== 4'b1111) begin n_fail++; $display("FAIL nonext_ignored: got %b expected %b", flags, exp_flags); end
        send_frame(8'hFF, 1'b0);
        n_checks++;
        if (flags !== 4'b0000) begin n_fail++; $display("FAIL overrun_clear: got %b expected 0000", flags); end
    endtask

    task automatic test_reset_midframe();
        logic [10:0] bits;
        send_frame(8'hE0, 1'b0);
        send_frame(8'h75, 1'b0);
        bits = frame_bits(8'h6B, 1'b0);
        for (int i = 0; i < 6; i++) ps2_bit(bits[i]);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        model_reset();
        @(negedge clock);
        n_checks++;
        if (flags !== 4'b0000 || scan_code !== 8'h00 || scan_valid !== 1'b0 || frame_error !== 1'b0) begin
            n_fail++; $display("FAIL midframe_reset_outputs: got flags=%b code=%h valid=%b err=%b expected all zero",
                                flags, scan_code, scan_valid, frame_error);
        end
        send_frame(8'hE0, 1'b0);
        send_frame(8'h74, 1'b0);
        n_checks++;
        if (flags !== 4'b1000 || scan_code !== 8'h74) begin
            n_fail++; $display("FAIL midframe_recover: got flags=%b code=%h expected flags=1000 code=74", flags, scan_code);
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic       bad;
        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 9))
                0, 1:    b = 8'hE0;
                2:       b = 8'hF0;
                3:       b = 8'h75;
                4:       b = 8'h72;
                5:       b = 8'h6B;
                6:       b = 8'h74;
                7:       b = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
                default: b = 8'($urandom_range(0, 255));
            endcase
            bad = ($urandom_range(0, 9) == 0);
            send_frame(b, bad);
            n_checks++;
            if (flags !== exp_flags || scan_code !== exp_code) begin
                n_fail++; $display("FAIL random_step%0d byte=%h bad=%b: got flags=%b code=%h expected flags=%b code=%h",
                                    n, b, bad, flags, scan_code, exp_flags, exp_code);
            end
        end
        n_checks++;
        if (sv_seen !== exp_sv || fe_seen !== exp_fe) begin
            n_fail++; $display("FAIL pulse_totals: got valid=%0d err=%0d expected valid=%0d err=%0d", sv_seen, fe_seen, exp_sv, exp_fe);
        end
    endtask

    initial begin
        test_reset();
        test_forward_press();
        test_forward_release();
        test_two_keys();
        test_bad_parity();
        test_timeout();
        test_nonext_overrun();
        test_reset_midframe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
